// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle signed restoring divider, fixed WIDTH+3 cycle latency.
// Optional macro DIV_REMAINDER_OUT_EN exposes the signed remainder as data_remainder.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
`ifdef DIV_REMAINDER_OUT_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             data_resultRDY
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic [WIDTH-1:0] remout_q, remout_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             sign_a, sign_b;
  logic             b_zero, ovf;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  assign sign_a = opa_q[WIDTH-1];
  assign sign_b = opb_q[WIDTH-1];
  assign b_zero = (opb_q == '0);
  assign ovf    = (opa_q == {1'b1, {(WIDTH-1){1'b0}}}) && (opb_q == '1);

  // Top bit of the shifted pair is always zero since rem < |B| <= 2^(WIDTH-1).
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, div_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    result_d = result_q;
    exc_d    = exc_q;
    remout_d = remout_q;
    unique case (state_q)
      S_SETUP: begin
        rem_d   = '0;
        quo_d   = sign_a ? neg(opa_q) : opa_q;
        div_d   = sign_b ? neg(opb_q) : opb_q;
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
        end
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        if (b_zero) begin
          result_d = '0;
          exc_d    = 1'b1;
          remout_d = opa_q;
        end else if (ovf) begin
          result_d = {1'b1, {(WIDTH-1){1'b0}}};
          exc_d    = 1'b1;
          remout_d = '0;
        end else begin
          result_d = (sign_a ^ sign_b) ? neg(quo_q) : quo_q;
          exc_d    = 1'b0;
          remout_d = sign_a ? neg(rem_q) : rem_q;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A start strobe in any state discards the in-flight division.
    if (ctrl_DIV) begin
      state_d = S_SETUP;
      opa_d   = data_operandA;
      opb_d   = data_operandB;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      remout_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      remout_q <= remout_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == S_DONE);

`ifdef DIV_REMAINDER_OUT_EN
  assign data_remainder = remout_q;
`else
  logic unused_remout;
  assign unused_remout = ^remout_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit; cycle k is the value seen at edge k.
module tb_div_unit;

  logic        clock;
  logic        reset;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [31:0] rem_w;

  int vectors;
  int miscompares;

  div_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
`ifdef DIV_REMAINDER_OUT_EN
    .data_remainder (rem_w),
`endif
    .data_resultRDY (data_resultRDY)
  );

`ifndef DIV_REMAINDER_OUT_EN
  assign rem_w = '0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives the start strobe so it is sampled at the next edge (cycle 0).
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'hDEADBEEF;
    data_operandB = 32'h0BADF00D;
  endtask

  task automatic observe(input int ncyc, output int first, output int nrdy,
                         output logic [31:0] res, output logic exc, output logic [31:0] rem);
    first = -1; nrdy = 0; res = '0; exc = 1'b0; rem = '0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        nrdy++;
        if (first < 0) begin
          first = k; res = data_result; exc = data_exception; rem = rem_w;
        end
      end
    end
  endtask

  task automatic check_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eres, input logic eexc, input logic [31:0] erem);
    int first, nrdy;
    logic [31:0] res, rem;
    logic exc;
    start(a, b);
    observe(40, first, nrdy, res, exc, rem);
    vectors++;
    if (first !== 35 || nrdy !== 1) begin
      miscompares++;
      $display("FAIL %s strobe: cycle=%0d count=%0d, required cycle=35 count=1", name, first, nrdy);
    end
    vectors++;
    if (res !== eres || exc !== eexc) begin
      miscompares++;
      $display("FAIL %s result: got %h exc=%b, required %h exc=%b", name, res, exc, eres, eexc);
    end
`ifdef DIV_REMAINDER_OUT_EN
    vectors++;
    if (rem !== erem) begin
      miscompares++;
      $display("FAIL %s remainder: got %h, required %h", name, rem, erem);
    end
`else
    if (erem === 32'hx) $display("note: remainder expectation is unknown");
`endif
  endtask

  task automatic test_reset();
    int first, nrdy;
    logic [31:0] res, rem;
    logic exc;
    reset = 1'b1; ctrl_DIV = 1'b1; data_operandA = 32'd100; data_operandB = 32'd7;
    repeat (2) @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    @(negedge clock);
    vectors++;
    if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0 || rem_w !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: result=%h exc=%b rdy=%b rem=%h, required all 0",
               data_result, data_exception, data_resultRDY, rem_w);
    end
    reset = 1'b0;
    observe(40, first, nrdy, res, exc, rem);
    vectors++;
    if (nrdy !== 0) begin
      miscompares++;
      $display("FAIL reset_wins_over_start: strobes=%0d, required 0", nrdy);
    end
  endtask

  task automatic test_basic();
    check_div("basic_100_7", 32'd100, 32'd7, 32'd14, 1'b0, 32'd2);
  endtask

  task automatic test_signed();
    check_div("neg_dividend", 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 1'b0, 32'hFFFFFFFE);
    check_div("neg_divisor", 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 32'd2);
    check_div("both_neg", 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 1'b0, 32'hFFFFFFFE);
  endtask

  task automatic test_div_zero();
    check_div("div_by_zero", 32'd5, 32'd0, 32'd0, 1'b1, 32'd5);
    check_div("after_div_zero", 32'd6, 32'd3, 32'd2, 1'b0, 32'd0);
  endtask

  task automatic test_overflow();
    check_div("overflow", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 32'd0);
    check_div("min_by_one", 32'h80000000, 32'd1, 32'h80000000, 1'b0, 32'd0);
  endtask

  task automatic test_restart();
    int first = -1, nrdy = 0, hold_bad = 0;
    logic [31:0] res = '0;
    start(32'd100, 32'd7);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clock);
      if (k < 45 && data_result !== 32'h80000000) hold_bad++;
      if (data_resultRDY) begin
        nrdy++;
        if (first < 0) begin first = k; res = data_result; end
      end
      if (k == 10) begin
        ctrl_DIV = 1'b1; data_operandA = 32'd81; data_operandB = 32'd9;
      end else begin
        ctrl_DIV = 1'b0;
      end
    end
    vectors++;
    if (first !== 45 || nrdy !== 1) begin
      miscompares++;
      $display("FAIL restart_strobe: cycle=%0d count=%0d, required cycle=45 count=1", first, nrdy);
    end
    vectors++;
    if (res !== 32'd9) begin
      miscompares++;
      $display("FAIL restart_result: got %h, required %h", res, 32'd9);
    end
    vectors++;
    if (hold_bad !== 0) begin
      miscompares++;
      $display("FAIL restart_hold: %0d cycles changed before strobe, required 0", hold_bad);
    end
  endtask

  task automatic test_reset_abort();
    int first = -1, nrdy = 0;
    logic [31:0] res = '0;
    start(32'd100, 32'd7);
    for (int k = 1; k <= 70; k++) begin
      @(negedge clock);
      if (k == 21) begin
        vectors++;
        if (data_result !== 32'd0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_clears: result=%h exc=%b rdy=%b, required 0 0 0",
                   data_result, data_exception, data_resultRDY);
        end
      end
      if (data_resultRDY) begin
        nrdy++;
        if (first < 0) begin first = k; res = data_result; end
      end
      reset = (k == 20);
      if (k == 22) begin
        ctrl_DIV = 1'b1; data_operandA = 32'd9; data_operandB = 32'd3;
      end else begin
        ctrl_DIV = 1'b0;
      end
    end
    vectors++;
    if (first !== 57 || nrdy !== 1) begin
      miscompares++;
      $display("FAIL abort_strobe: cycle=%0d count=%0d, required cycle=57 count=1", first, nrdy);
    end
    vectors++;
    if (res !== 32'd3) begin
      miscompares++;
      $display("FAIL abort_result: got %h, required %h", res, 32'd3);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_restart();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle signed 32-bit integer divider in the ALU/multdiv datapath.
- Operand magnitudes are formed by bitwise inversion through the existing 32-bit NOT stage plus an incrementer. Quotient and remainder sign correction use the same NOT stage.
- Started by a single-cycle ctrl_DIV pulse from the processor's execute stage. Reports completion with a one-cycle data_resultRDY strobe, which the pipeline stall logic consumes.

Parameters:
- WIDTH, 32, operand/result width in bits; only 32 is supported by the processor.
- Latency is fixed at WIDTH+3 cycles and is not a parameter.

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  synchronous, active-high; takes effect on the rising edge of clock
- ctrl_DIV  input  1  start strobe, sampled each rising edge; latches operands
- data_operandA  input  WIDTH  dividend, two's complement
- data_operandB  input  WIDTH  divisor, two's complement
- data_result  output  WIDTH  quotient, truncated toward zero
- data_exception  output  1  divide-by-zero or overflow flag, valid with data_result
- data_resultRDY  output  1  one-cycle completion strobe

Behaviour:
- Reset values: data_result=0, data_exception=0, data_resultRDY=0, state=IDLE, iteration counter=0. Reset mid-operation aborts immediately; no strobe follows.
- States:
  - IDLE
  - SETUP: 1 cycle
  - ITER: WIDTH cycles
  - FIX: 1 cycle
  - DONE: 1 cycle
- Start: ctrl_DIV=1 at edge T latches A, B, and sign flags sA=A[31], sB=B[31]; state goes to SETUP.
- SETUP: |A| and |B| are computed as (~x)+1 when the sign bit is set, else x. Remainder register is cleared; quotient register gets |A|; divisor register gets |B|; counter is cleared.
- ITER: restoring shift-subtract, one quotient bit per cycle.
  - The {rem,quo} pair shifts left 1.
  - trial = rem - |B| at WIDTH+1 bits.
  - If trial is non-negative, rem=trial and quo[0]=1; else quo[0]=0.
  - Counter increments; after WIDTH iterations, go to FIX.
- FIX:
  - Quotient is negated (~q+1) when sA^sB.
  - Remainder is negated when sA (remainder sign follows dividend).
  - Exceptions:
    - B==0: result=0, exception=1.
    - A==32'h80000000 and B==32'hFFFFFFFF: result=32'h80000000, exception=1.
    - Otherwise exception=0.
- DONE: data_resultRDY=1 for exactly one cycle, at edge T+WIDTH+3 (T+35 for WIDTH=32). Then state goes to IDLE.
- data_result and data_exception update only on entry to DONE. They hold their values until the next DONE or reset, including through a subsequent busy period.
- ctrl_DIV while busy (any non-IDLE state, including DONE) restarts with the new operands at that edge. The in-flight division is discarded and produces no strobe.
- ctrl_DIV in the same cycle as reset: reset wins; state stays IDLE.
- data_operandA/B are don't-care except at the ctrl_DIV edge.

Optional Feature:
- Macro: DIV_REMAINDER_OUT_EN.
- Defined: adds output port data_remainder (WIDTH bits).
  - Reset value 0.
  - Updated with data_result on entry to DONE; signed remainder with the sign of the dividend.
  - On B==0 it reports the dividend A unchanged.
  - On overflow it reports 0.
- Undefined: no data_remainder port. The remainder register remains internal, and all other timing is identical.

Test Plan:
- A=100, B=7, ctrl_DIV pulse at cycle 0 -> data_resultRDY high only at cycle 35. data_result=14, exception=0. data_remainder=2 when DIV_REMAINDER_OUT_EN is defined.
- A=-100 (32'hFFFFFF9C), B=7 -> result=-14 (32'hFFFFFFF2), remainder=-2. With A=100, B=-7 -> result=-14, remainder=2.
- A=5, B=0 -> at cycle 35 result=0, exception=1, remainder=5. Next division 6/3 -> result=2, exception cleared to 0.
- A=32'h80000000, B=32'hFFFFFFFF -> result=32'h80000000, exception=1. A=32'h80000000, B=1 -> result=32'h80000000, exception=0.
- Start 100/7 at cycle 0, re-pulse ctrl_DIV with 81/9 at cycle 10 -> no strobe at cycle 35. Strobe at cycle 45 with result=9; data_result holds its previous value until then.
- Start 100/7, assert reset at cycle 20 for one cycle -> all outputs 0, no strobe ever. A fresh 9/3 started at cycle 22 gives a strobe at cycle 57 with result=3.
